// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder for the MEM-stage data bus: output port, synchronized input
// port with sticky rising-edge flags, a one-shot countdown timer and a free-running cycle counter.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        TimerDone
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} TimerState;

    localparam logic [2:0] REG_PORT_OUT     = 3'd0;
    localparam logic [2:0] REG_PORT_IN      = 3'd1;
    localparam logic [2:0] REG_EDGE         = 3'd2;
    localparam logic [2:0] REG_TIMER_LOAD   = 3'd3;
    localparam logic [2:0] REG_TIMER_STATUS = 3'd4;
    localparam logic [2:0] REG_CYCLE        = 3'd5;

    TimerState   timerState;
    logic [31:0] count;
    logic [31:0] cycleCount;
    logic        cycleStarted;
    logic [7:0]  sync1, sync2, prev;
    logic [7:0]  edgeFlags;
    logic [7:0]  risePulse;
    logic [2:0]  regIdx;
    logic        aligned;
    logic        wrAccess;
    logic        rdAccess;
    logic        wrPortOut, wrEdge, wrTimerLoad, wrTimerStatus;
    logic        running;

    assign Hit      = (Address[31:5] == BASE_ADDR[31:5]);
    assign aligned  = (Address[1:0] == 2'b00);
    assign regIdx   = Address[4:2];
    assign wrAccess = MemWrite & Hit & aligned;
    assign rdAccess = MemRead & Hit & aligned;

    assign wrPortOut     = wrAccess && (regIdx == REG_PORT_OUT);
    assign wrEdge        = wrAccess && (regIdx == REG_EDGE);
    assign wrTimerLoad   = wrAccess && (regIdx == REG_TIMER_LOAD);
    assign wrTimerStatus = wrAccess && (regIdx == REG_TIMER_STATUS);

    assign risePulse = sync2 & ~prev;
    assign running   = (timerState == RUN);
    assign TimerDone = (timerState == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut   <= 32'd0;
            sync1     <= 8'd0;
            sync2     <= 8'd0;
            prev      <= 8'd0;
            edgeFlags <= 8'd0;
        end else begin
            if (wrPortOut)
                PortOut <= WriteData;
            sync1 <= PortIn;
            sync2 <= sync1;
            prev  <= sync2;
            // A new rise on a bit beats a simultaneous write-1-to-clear of that bit.
            edgeFlags <= (edgeFlags & ~(wrEdge ? WriteData[7:0] : 8'd0)) | risePulse;
        end
    end

    // Timer: a load always restarts it, whatever state it is in; a zero load finishes at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            timerState <= IDLE;
            count      <= 32'd0;
        end else if (wrTimerLoad) begin
            count      <= WriteData;
            timerState <= (WriteData == 32'd0) ? DONE : RUN;
        end else begin
            case (timerState)
                IDLE: ;
                RUN: begin
                    if (count == 32'd1) begin
                        count      <= 32'd0;
                        timerState <= DONE;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                DONE: begin
                    if (wrTimerStatus)
                        timerState <= IDLE;
                end
                default: timerState <= IDLE;
            endcase
        end
    end

    // The counter holds 0 for the first edge out of reset so it reads k-1 after the k-th edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount   <= 32'd0;
            cycleStarted <= 1'b0;
        end else begin
            cycleStarted <= 1'b1;
            if (cycleStarted)
                cycleCount <= cycleCount + 32'd1;
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (rdAccess) begin
            case (regIdx)
                REG_PORT_OUT:     ReadData = PortOut;
                REG_PORT_IN:      ReadData = {24'd0, sync2};
                REG_EDGE:         ReadData = {24'd0, edgeFlags};
                REG_TIMER_LOAD:   ReadData = count;
                REG_TIMER_STATUS: ReadData = {30'd0, running, TimerDone};
                REG_CYCLE:        ReadData = cycleCount;
                default:          ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: expectations are queued as each access is
// driven and compared when the responder's output is sampled.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE         = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_OUT     = BASE + 32'h00;
    localparam logic [31:0] ADDR_IN      = BASE + 32'h04;
    localparam logic [31:0] ADDR_EDGE    = BASE + 32'h08;
    localparam logic [31:0] ADDR_TLOAD   = BASE + 32'h0C;
    localparam logic [31:0] ADDR_TSTATUS = BASE + 32'h10;
    localparam logic [31:0] ADDR_CYCLE   = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        TimerDone;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } Expectation;

    Expectation scoreboard[$];

    mmio_port_responder #(.BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .PortIn(PortIn),
        .ReadData(ReadData),
        .Hit(Hit),
        .PortOut(PortOut),
        .TimerDone(TimerDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        Expectation e;
        e.tag   = tag;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    task automatic popCompare(input logic [31:0] observed);
        Expectation e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got %h with no expectation queued", observed);
        end else begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = we;
        MemRead   = re;
        Address   = addr;
        WriteData = data;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data);
        tick();
        applyStimulus(1'b0, 1'b0, addr, 32'd0);
    endtask

    task automatic doRead(input logic [31:0] addr, input string tag, input logic [31:0] expected);
        pushExpect(tag, expected);
        applyStimulus(1'b0, 1'b1, addr, 32'd0);
        #1;
        popCompare(ReadData);
        applyStimulus(1'b0, 1'b0, addr, 32'd0);
    endtask

    task automatic checkNow(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        pushExpect(tag, expected);
        popCompare(observed);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        PortIn = 8'h00;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();

        // Reset state
        checkNow("resetPortOut", PortOut, 32'd0);
        checkNow("resetTimerDone", {31'd0, TimerDone}, 32'd0);
        checkNow("resetReadData", ReadData, 32'd0);
        doRead(ADDR_CYCLE, "resetCycle", 32'd0);
        reset = 1'b0;
        tick();
        doRead(ADDR_CYCLE, "cycleFirst", 32'd0);
        tick();
        doRead(ADDR_CYCLE, "cycleSecond", 32'd1);

        // Output port
        doWrite(ADDR_OUT, 32'hDEAD_BEEF);
        checkNow("portOutWrite", PortOut, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, ADDR_OUT, 32'd0);
        #1;
        checkNow("readDataNoRead", ReadData, 32'd0);
        checkNow("hitInWindow", {31'd0, Hit}, 32'd1);
        doRead(ADDR_OUT, "portOutRead", 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, BASE + 32'h20, 32'h1234_5678);
        #1;
        checkNow("hitOutside", {31'd0, Hit}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkNow("portOutOutside", PortOut, 32'hDEAD_BEEF);
        doRead(BASE + 32'h20, "readOutside", 32'd0);

        // Input synchronizer and edge flags
        PortIn = 8'h05;
        tick();
        doRead(ADDR_IN, "portInEarly", 32'h00);
        tick();
        doRead(ADDR_IN, "portInSync", 32'h05);
        doRead(ADDR_EDGE, "edgeEarly", 32'h00);
        tick();
        doRead(ADDR_EDGE, "edgeSet", 32'h05);
        doWrite(ADDR_EDGE, 32'h01);
        doRead(ADDR_EDGE, "edgeClear", 32'h04);
        PortIn = 8'h04;
        for (int i = 0; i < 3; i++) tick();
        PortIn = 8'h05;
        tick();
        tick();
        doWrite(ADDR_EDGE, 32'h01);
        doRead(ADDR_EDGE, "edgeSetWins", 32'h05);

        // Timer countdown
        doWrite(ADDR_TLOAD, 32'd3);
        doRead(ADDR_TLOAD, "timerCount", 32'd3);
        for (int i = 0; i < 3; i++) begin
            doRead(ADDR_TSTATUS, "timerRunning", 32'h2);
            checkNow("timerNotDone", {31'd0, TimerDone}, 32'd0);
            tick();
        end
        checkNow("timerDone", {31'd0, TimerDone}, 32'd1);
        doRead(ADDR_TSTATUS, "timerStatusDone", 32'h1);
        doWrite(ADDR_TSTATUS, 32'd0);
        doRead(ADDR_TSTATUS, "timerStatusIdle", 32'h0);

        // Timer edge cases
        doWrite(ADDR_TLOAD, 32'd0);
        checkNow("timerZeroDone", {31'd0, TimerDone}, 32'd1);
        doWrite(ADDR_TSTATUS, 32'd0);
        doWrite(ADDR_TLOAD, 32'd10);
        for (int i = 0; i < 3; i++) tick();
        doWrite(ADDR_TLOAD, 32'd2);
        doRead(ADDR_TLOAD, "timerReloadCount", 32'd2);
        checkNow("timerReload0", {31'd0, TimerDone}, 32'd0);
        tick();
        checkNow("timerReload1", {31'd0, TimerDone}, 32'd0);
        tick();
        checkNow("timerReload2", {31'd0, TimerDone}, 32'd1);
        doWrite(ADDR_TSTATUS, 32'd0);

        doWrite(ADDR_TLOAD, 32'd50);
        tick();
        reset = 1'b1;
        tick();
        doRead(ADDR_TLOAD, "abortCount", 32'd0);
        doRead(ADDR_TSTATUS, "abortStatus", 32'h0);
        checkNow("abortTimerDone", {31'd0, TimerDone}, 32'd0);
        checkNow("abortPortOut", PortOut, 32'd0);
        doRead(ADDR_EDGE, "abortEdge", 32'd0);

        // Cycle counter and misaligned accesses
        reset = 1'b0;
        tick();
        doRead(ADDR_CYCLE, "cycleStart", 32'd0);
        for (int i = 0; i < 5; i++) tick();
        doRead(ADDR_CYCLE, "cycleDelta", 32'd5);
        doWrite(ADDR_OUT, 32'h0000_A5A5);
        doRead(BASE + 32'h02, "misalignedRead", 32'd0);
        doRead(ADDR_CYCLE, "cycleBeforeStore", 32'd6);
        doWrite(ADDR_CYCLE, 32'd0);
        doRead(ADDR_CYCLE, "cycleAfterStore", 32'd7);

        // Simultaneous load and store
        doWrite(ADDR_OUT, 32'h1);
        applyStimulus(1'b1, 1'b1, ADDR_OUT, 32'h2);
        #1;
        checkNow("rmwOldValue", ReadData, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b1, ADDR_OUT, 32'd0);
        #1;
        checkNow("rmwNewValue", ReadData, 32'h2);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboardDrain: got %0d leftover entries, expected 0", scoreboard.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
